branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  EX-stage consumer of the gshare predictor's output. Holds each fetched branch's prediction
//  (pc, predicted-taken, gshare index) in an in-order queue until the ALU resolves the branch.
//  Compares the actual outcome against the prediction and drives the predictor's update port.
//  On a mispredict it issues a pipeline flush and a fetch redirect.
// PARAMETERS
//  ADDRESS_WIDTH  22  instruction word-address width (matches predictor)
//  GHR_SIZE        8  width of the gshare index carried with each prediction
//  QUEUE_DEPTH     4  in-flight branch entries; power of 2, >=2
//  FLUSH_CYCLES    2  cycles o_flush is held after a mispredict; >=1
// PORTS
//  i_Clk              in   1    clock, rising edge
//  i_Reset            in   1    asynchronous, active-high reset
//  i_Stall            in   1    pipeline stall; blocks push, pop and update
//  i_fetch_valid      in   1    fetch stage holds a branch whose prediction is to be tracked
//  i_fetch_pc         in   AW   branch pc
//  i_fetch_taken      in   1    predictor o_taken for this branch
//  i_fetch_index      in   GHR  gshare index used for the prediction
//  o_fetch_ready      out  1    queue can accept a push this cycle
//  i_ex_valid         in   1    oldest branch resolves in EX this cycle
//  i_ex_taken         in   1    ALU outcome, 1 = taken
//  i_ex_target        in   AW   computed taken target
//  o_upd_valid        out  1    update strobe -> predictor i_ALU_isbranch
//  o_upd_pc           out  AW   -> i_ALU_pc
//  o_upd_index        out  GHR  index of the counter to correct
//  o_upd_outcome      out  1    -> i_ALU_outcome
//  o_upd_prediction   out  1    -> i_ALU_prediction
//  o_flush            out  1    squash younger pipeline stages
//  o_redirect_valid   out  1    one-cycle fetch redirect strobe
//  o_redirect_pc      out  AW   corrected fetch pc
//  o_mispredict_count out  16   saturating mispredict counter
//  o_underflow        out  1    sticky: resolve arrived with the queue empty
// BEHAVIOUR
//  Reset (async): queue empty, FSM=RUN, all outputs 0, o_fetch_ready=1 once reset is released.
//  Queue: o_fetch_ready = !full && state==RUN. Full does not accept a same-cycle pass-through.
//   push = i_fetch_valid & o_fetch_ready & !i_Stall.
//   pop  = i_ex_valid & !empty & !i_Stall & state==RUN.
//   push+pop in the same cycle: both occur, count unchanged. Pointers wrap modulo QUEUE_DEPTH.
//  i_ex_valid with an empty queue: no pop, no update, o_underflow <= 1 (cleared only by reset).
//  Resolve, latency 1: on pop, next cycle o_upd_valid=1 with the head entry's pc/index/prediction.
//   o_upd_outcome = i_ex_taken. An update is issued for every resolved branch.
//   mispredict = head.taken != i_ex_taken.
//  FSM RUN -> FLUSH on a mispredict pop. In the same next cycle as the update:
//   o_redirect_valid=1 for exactly 1 cycle;
//   o_redirect_pc = i_ex_taken ? i_ex_target : head.pc+1 (mod 2^AW);
//   o_flush=1 for FLUSH_CYCLES consecutive cycles;
//   queue pointers cleared (all younger entries are wrong-path);
//   o_mispredict_count += 1, saturating at 16'hFFFF.
//  FLUSH: push/pop/i_ex_valid ignored (no underflow flag); countdown runs even while i_Stall=1.
//   Returns to RUN after the last o_flush cycle.
//  Correct prediction: entry popped, update issued, no flush or redirect.
//  Stall: i_Stall=1 in RUN -> no push, no pop, o_upd_valid=0 next cycle, queue unchanged.
//  Reset asserted mid-FLUSH: immediate return to the reset state; counter cleared.
// STRUCTURE
//  Shared package bp_pkg:
//   FSM state encodings (S_RUN, S_FLUSH);
//   queue entry field offsets/width (pc, taken, index);
//   ADDRESS_WIDTH/GHR_SIZE defaults shared with branch_predictor.
//  Sub-module bp_pred_queue: synchronous FIFO, async active-high reset.
//   Ports: push/pop/clear, full/empty, head data.
//  Top level: FSM, flush counter, mispredict compare, update/redirect registers, stat counter.
// TESTING
//  1 push pc=0x10 taken=1 idx=0x3A; ex_valid taken=1 -> upd_valid 1 cyc later, upd_index=0x3A,
//    outcome=1, prediction=1; no flush, no redirect.
//  2 push pc=0x20 taken=0; ex taken=1 target=0x40 -> redirect_valid 1 cyc, redirect_pc=0x40,
//    flush high 2 cyc, count=1.
//  3 push pc=0x30 taken=1; ex taken=0 -> redirect_pc=0x31. Push 3 younger branches first ->
//    queue empty after the flush.
//  4 push 4 branches -> o_fetch_ready=0; 5th push ignored; push+pop at 3 entries -> count stays 3.
//  5 ex_valid on an empty queue -> o_underflow=1, no upd_valid. ex_valid during FLUSH -> ignored,
//    no underflow.
//  6 force 65536 mispredicts -> count holds 0xFFFF. Reset during FLUSH -> flush=0, ready=1, count=0.

Source files
------------

// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch prediction slice (predictor and the
// branch resolve unit). Holds the default address / gshare index widths,
// the resolve FSM state encodings and the layout of one in-flight queue
// entry. The entry is packed as {index, taken, pc} with pc in the low bits.
// ---------------------------------------------------------------------------
package bp_pkg;

  localparam int BP_ADDRESS_WIDTH = 22;
  localparam int BP_GHR_SIZE      = 8;

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  // Entry field positions depend on the address width chosen by the user of
  // the package, so they are exposed as constant functions.
  function automatic int entry_pc_lsb();
    return 0;
  endfunction

  function automatic int entry_taken_bit(input int aw);
    return aw;
  endfunction

  function automatic int entry_index_lsb(input int aw);
    return aw + 1;
  endfunction

  function automatic int entry_width(input int aw, input int ghr);
    return aw + 1 + ghr;
  endfunction

endpackage

// File: rtl/bp_pred_queue.sv
// ---------------------------------------------------------------------------
// bp_pred_queue
// Small synchronous FIFO holding the predictions of branches that have been
// fetched but not yet resolved. Async active-high reset.
// Ports:
//   i_Clk, i_Reset   clock, asynchronous active-high reset
//   i_push, i_data   write one entry at the tail (ignored when full)
//   i_pop            drop the head entry (ignored when empty)
//   i_clear          discard every entry; wins over push and pop
//   o_full, o_empty  occupancy flags
//   o_head           oldest entry (valid while !o_empty)
// ---------------------------------------------------------------------------
module bp_pred_queue #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] L_FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == L_FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage has no reset; entries are only read while counted as occupied.
  always_ff @(posedge i_Clk) begin
    if (w_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// EX-stage partner of the gshare predictor. Each fetched branch's prediction
// is queued in order; when the ALU resolves the oldest branch the outcome is
// compared with the prediction, the predictor update port is driven one
// cycle later and, on a mispredict, the pipeline is flushed and fetch is
// redirected to the correct path.
// Ports:
//   i_Clk, i_Reset      clock, asynchronous active-high reset
//   i_Stall             freezes push, pop and update (flush countdown runs)
//   i_fetch_*           branch prediction to track; o_fetch_ready = can push
//   i_ex_*              resolution of the oldest tracked branch
//   o_upd_*             predictor update port (registered)
//   o_flush             squash younger stages for FLUSH_CYCLES cycles
//   o_redirect_*        one-cycle corrected fetch pc
//   o_mispredict_count  saturating mispredict statistic
//   o_underflow         sticky: a resolve arrived with nothing queued
// ---------------------------------------------------------------------------
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int ADDRESS_WIDTH = BP_ADDRESS_WIDTH,
  parameter int GHR_SIZE      = BP_GHR_SIZE,
  parameter int QUEUE_DEPTH   = 4,
  parameter int FLUSH_CYCLES  = 2
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_Stall,
  input  logic                     i_fetch_valid,
  input  logic [ADDRESS_WIDTH-1:0] i_fetch_pc,
  input  logic                     i_fetch_taken,
  input  logic [GHR_SIZE-1:0]      i_fetch_index,
  output logic                     o_fetch_ready,
  input  logic                     i_ex_valid,
  input  logic                     i_ex_taken,
  input  logic [ADDRESS_WIDTH-1:0] i_ex_target,
  output logic                     o_upd_valid,
  output logic [ADDRESS_WIDTH-1:0] o_upd_pc,
  output logic [GHR_SIZE-1:0]      o_upd_index,
  output logic                     o_upd_outcome,
  output logic                     o_upd_prediction,
  output logic                     o_flush,
  output logic                     o_redirect_valid,
  output logic [ADDRESS_WIDTH-1:0] o_redirect_pc,
  output logic [15:0]              o_mispredict_count,
  output logic                     o_underflow
);

  localparam int L_ENTRY_W   = entry_width(ADDRESS_WIDTH, GHR_SIZE);
  localparam int L_PC_LSB    = entry_pc_lsb();
  localparam int L_TAKEN_BIT = entry_taken_bit(ADDRESS_WIDTH);
  localparam int L_INDEX_LSB = entry_index_lsb(ADDRESS_WIDTH);
  localparam int L_FC_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [L_FC_W-1:0] L_FC_LOAD = L_FC_W'(FLUSH_CYCLES - 1);

  logic [0:0]               r_state;
  logic [L_FC_W-1:0]        r_flush_cnt;
  logic [15:0]              r_mispredict_count;

  logic                     w_run;
  logic                     w_full;
  logic                     w_empty;
  logic [L_ENTRY_W-1:0]     w_head;
  logic [L_ENTRY_W-1:0]     w_entry;
  logic [ADDRESS_WIDTH-1:0] w_head_pc;
  logic                     w_head_taken;
  logic [GHR_SIZE-1:0]      w_head_index;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_mispredict;
  logic                     w_underflow_hit;

  assign w_run         = (r_state == S_RUN);
  assign o_fetch_ready = ~w_full & w_run;

  assign w_push          = i_fetch_valid & o_fetch_ready & ~i_Stall;
  assign w_pop           = i_ex_valid & ~w_empty & ~i_Stall & w_run;
  assign w_mispredict    = w_pop & (w_head_taken != i_ex_taken);
  assign w_underflow_hit = i_ex_valid & w_empty & w_run;

  assign w_entry      = {i_fetch_index, i_fetch_taken, i_fetch_pc};
  assign w_head_pc    = w_head[L_PC_LSB +: ADDRESS_WIDTH];
  assign w_head_taken = w_head[L_TAKEN_BIT];
  assign w_head_index = w_head[L_INDEX_LSB +: GHR_SIZE];

  assign o_flush            = (r_state == S_FLUSH);
  assign o_mispredict_count = r_mispredict_count;

  // A mispredict clears the queue: every younger entry came from the wrong
  // path, so the clear overrides any push landing in the same cycle.
  bp_pred_queue #(
    .WIDTH (L_ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_mispredict),
    .i_data  (w_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // RUN/FLUSH control. FLUSH lasts exactly FLUSH_CYCLES cycles and counts
  // down regardless of stall so the front end is never squashed forever.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_state     <= S_RUN;
      r_flush_cnt <= '0;
    end else if (r_state == S_RUN) begin
      if (w_mispredict) begin
        r_state     <= S_FLUSH;
        r_flush_cnt <= L_FC_LOAD;
      end
    end else begin
      if (r_flush_cnt == '0) begin
        r_state <= S_RUN;
      end else begin
        r_flush_cnt <= r_flush_cnt - 1'b1;
      end
    end
  end

  // Predictor update and fetch redirect, both one cycle after the pop.
  // Data fields hold their last value; only the strobes are meaningful.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_upd_valid      <= 1'b0;
      o_upd_pc         <= '0;
      o_upd_index      <= '0;
      o_upd_outcome    <= 1'b0;
      o_upd_prediction <= 1'b0;
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= '0;
    end else begin
      o_upd_valid      <= w_pop;
      o_redirect_valid <= w_mispredict;
      if (w_pop) begin
        o_upd_pc         <= w_head_pc;
        o_upd_index      <= w_head_index;
        o_upd_outcome    <= i_ex_taken;
        o_upd_prediction <= w_head_taken;
      end
      if (w_mispredict) begin
        o_redirect_pc <= i_ex_taken ? i_ex_target : (w_head_pc + 1'b1);
      end
    end
  end

  // Statistics: saturating mispredict counter and sticky underflow flag.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_mispredict_count <= '0;
      o_underflow        <= 1'b0;
    end else begin
      if (w_mispredict && (r_mispredict_count != 16'hFFFF)) begin
        r_mispredict_count <= r_mispredict_count + 16'd1;
      end
      if (w_underflow_hit) begin
        o_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed bench for branch_resolve_unit with default parameters
// (AW=22, GHR=8, depth 4, flush 2 cycles). Inputs change 1 time unit after
// a rising edge; outputs are checked at that same point, i.e. they show
// the effect of the edge just passed.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

  logic        i_Clk;
  logic        i_Reset;
  logic        i_Stall;
  logic        i_fetch_valid;
  logic [21:0] i_fetch_pc;
  logic        i_fetch_taken;
  logic [7:0]  i_fetch_index;
  logic        o_fetch_ready;
  logic        i_ex_valid;
  logic        i_ex_taken;
  logic [21:0] i_ex_target;
  logic        o_upd_valid;
  logic [21:0] o_upd_pc;
  logic [7:0]  o_upd_index;
  logic        o_upd_outcome;
  logic        o_upd_prediction;
  logic        o_flush;
  logic        o_redirect_valid;
  logic [21:0] o_redirect_pc;
  logic [15:0] o_mispredict_count;
  logic        o_underflow;

  int checks;
  int errors;

  branch_resolve_unit dut (
    .i_Clk              (i_Clk),
    .i_Reset            (i_Reset),
    .i_Stall            (i_Stall),
    .i_fetch_valid      (i_fetch_valid),
    .i_fetch_pc         (i_fetch_pc),
    .i_fetch_taken      (i_fetch_taken),
    .i_fetch_index      (i_fetch_index),
    .o_fetch_ready      (o_fetch_ready),
    .i_ex_valid         (i_ex_valid),
    .i_ex_taken         (i_ex_taken),
    .i_ex_target        (i_ex_target),
    .o_upd_valid        (o_upd_valid),
    .o_upd_pc           (o_upd_pc),
    .o_upd_index        (o_upd_index),
    .o_upd_outcome      (o_upd_outcome),
    .o_upd_prediction   (o_upd_prediction),
    .o_flush            (o_flush),
    .o_redirect_valid   (o_redirect_valid),
    .o_redirect_pc      (o_redirect_pc),
    .o_mispredict_count (o_mispredict_count),
    .o_underflow        (o_underflow)
  );

  // 10-unit clock period.
  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  // Drive every DUT input for the next clock edge.
  task automatic applyStimulus(input logic fv, input logic [21:0] pc, input logic tk,
                               input logic [7:0] idx, input logic exv, input logic ext,
                               input logic [21:0] tgt, input logic stall);
    i_fetch_valid = fv;
    i_fetch_pc    = pc;
    i_fetch_taken = tk;
    i_fetch_index = idx;
    i_ex_valid    = exv;
    i_ex_taken    = ext;
    i_ex_target   = tgt;
    i_Stall       = stall;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 22'h0, 1'b0, 8'h0, 1'b0, 1'b0, 22'h0, 1'b0);
  endtask

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    i_Reset = 1'b1;
    idle();

    // ---- reset state ----
    step();
    step();
    checkOutput("rst_upd_valid", 32'(o_upd_valid), 32'd0);
    checkOutput("rst_flush", 32'(o_flush), 32'd0);
    checkOutput("rst_redirect", 32'(o_redirect_valid), 32'd0);
    checkOutput("rst_count", 32'(o_mispredict_count), 32'd0);
    checkOutput("rst_underflow", 32'(o_underflow), 32'd0);
    i_Reset = 1'b0;
    #1;
    checkOutput("rst_ready", 32'(o_fetch_ready), 32'd1);
    step();

    // ---- 1: correct taken prediction ----
    $display("[TB] correct prediction");
    applyStimulus(1'b1, 22'h10, 1'b1, 8'h3A, 1'b0, 1'b0, 22'h0, 1'b0);
    step();
    applyStimulus(1'b0, 22'h0, 1'b0, 8'h0, 1'b1, 1'b1, 22'h0, 1'b0);
    checkOutput("t1_no_early_upd", 32'(o_upd_valid), 32'd0);
    step();
    idle();
    checkOutput("t1_upd_valid", 32'(o_upd_valid), 32'd1);
    checkOutput("t1_upd_pc", 32'(o_upd_pc), 32'h10);
    checkOutput("t1_upd_index", 32'(o_upd_index), 32'h3A);
    checkOutput("t1_outcome", 32'(o_upd_outcome), 32'd1);
    checkOutput("t1_prediction", 32'(o_upd_prediction), 32'd1);
    checkOutput("t1_flush", 32'(o_flush), 32'd0);
    checkOutput("t1_redirect", 32'(o_redirect_valid), 32'd0);
    step();
    checkOutput("t1_upd_drop", 32'(o_upd_valid), 32'd0);

    // ---- 2: predicted not-taken, actually taken ----
    $display("[TB] mispredict taken");
    applyStimulus(1'b1, 22'h20, 1'b0, 8'h11, 1'b0, 1'b0, 22'h0, 1'b0);
    step();
    applyStimulus(1'b0, 22'h0, 1'b0, 8'h0, 1'b1, 1'b1, 22'h40, 1'b0);
    step();
    idle();
    checkOutput("t2_upd_valid", 32'(o_upd_valid), 32'd1);
    checkOutput("t2_upd_index", 32'(o_upd_index), 32'h11);
    checkOutput("t2_prediction", 32'(o_upd_prediction), 32'd0);
    checkOutput("t2_redirect_valid", 32'(o_redirect_valid), 32'd1);
    checkOutput("t2_redirect_pc", 32'(o_redirect_pc), 32'h40);
    checkOutput("t2_flush_c1", 32'(o_flush), 32'd1);
    checkOutput("t2_ready_in_flush", 32'(o_fetch_ready), 32'd0);
    checkOutput("t2_count", 32'(o_mispredict_count), 32'd1);
    step();
    checkOutput("t2_redirect_1cyc", 32'(o_redirect_valid), 32'd0);
    checkOutput("t2_flush_c2", 32'(o_flush), 32'd1);
    step();
    checkOutput("t2_flush_end", 32'(o_flush), 32'd0);
    checkOutput("t2_ready_back", 32'(o_fetch_ready), 32'd1);

    // ---- 3: predicted taken, not taken, with younger entries queued ----
    $display("[TB] mispredict not-taken with younger branches");
    applyStimulus(1'b1, 22'h30, 1'b1, 8'h05, 1'b0, 1'b0, 22'h0, 1'b0);
    step();
    applyStimulus(1'b1, 22'h34, 1'b0, 8'h06, 1'b0, 1'b0, 22'h0, 1'b0);
    step();
    applyStimulus(1'b1, 22'h38, 1'b0, 8'h07, 1'b0, 1'b0, 22'h0, 1'b0);
    step();
    applyStimulus(1'b1, 22'h3C, 1'b0, 8'h08, 1'b0, 1'b0, 22'h0, 1'b0);
    step();
    checkOutput("t3_full", 32'(o_fetch_ready), 32'd0);
    applyStimulus(1'b0, 22'h0, 1'b0, 8'h0, 1'b1, 1'b0, 22'h77, 1'b0);
    step();
    // Resolve and push attempts during FLUSH must be ignored.
    applyStimulus(1'b1, 22'h99, 1'b1, 8'h99, 1'b1, 1'b0, 22'h0, 1'b0);
    checkOutput("t3_redirect_pc", 32'(o_redirect_pc), 32'h31);
    checkOutput("t3_outcome", 32'(o_upd_outcome), 32'd0);
    checkOutput("t3_count", 32'(o_mispredict_count), 32'd2);
    step();
    checkOutput("t3_flush_no_upd", 32'(o_upd_valid), 32'd0);
    step();
    idle();
    checkOutput("t3_flush_no_underflow", 32'(o_underflow), 32'd0);
    checkOutput("t3_flush_end", 32'(o_flush), 32'd0);

    // ---- 5: resolve with an empty queue (younger entries were discarded) ----
    $display("[TB] underflow");
    applyStimulus(1'b0, 22'h0, 1'b0, 8'h0, 1'b1, 1'b1, 22'h0, 1'b0);
    step();
    idle();
    checkOutput("t5_underflow", 32'(o_underflow), 32'd1);
    checkOutput("t5_no_upd", 32'(o_upd_valid), 32'd0);
    step();
    checkOutput("t5_sticky", 32'(o_underflow), 32'd1);

    // ---- 4: full queue, ignored 5th push, push+pop ----
    $display("[TB] queue full and push+pop");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 22'(22'h100 + i), 1'b1, 8'(i + 1), 1'b0, 1'b0, 22'h0, 1'b0);
      step();
    end
    checkOutput("t4_full", 32'(o_fetch_ready), 32'd0);
    applyStimulus(1'b1, 22'h104, 1'b1, 8'h05, 1'b0, 1'b0, 22'h0, 1'b0);
    step();
    applyStimulus(1'b0, 22'h0, 1'b0, 8'h0, 1'b1, 1'b1, 22'h0, 1'b0);
    step();
    checkOutput("t4_pop0_pc", 32'(o_upd_pc), 32'h100);
    checkOutput("t4_ready_at3", 32'(o_fetch_ready), 32'd1);
    applyStimulus(1'b1, 22'h105, 1'b1, 8'h06, 1'b1, 1'b1, 22'h0, 1'b0);
    step();
    checkOutput("t4_pushpop_pc", 32'(o_upd_pc), 32'h101);
    checkOutput("t4_count_stays3", 32'(o_fetch_ready), 32'd1);
    applyStimulus(1'b1, 22'h106, 1'b1, 8'h07, 1'b0, 1'b0, 22'h0, 1'b0);
    step();
    checkOutput("t4_full_again", 32'(o_fetch_ready), 32'd0);
    applyStimulus(1'b0, 22'h0, 1'b0, 8'h0, 1'b1, 1'b1, 22'h0, 1'b0);
    step();
    checkOutput("t4_pop_102", 32'(o_upd_pc), 32'h102);
    step();
    checkOutput("t4_pop_103", 32'(o_upd_pc), 32'h103);
    step();
    checkOutput("t4_pop_105", 32'(o_upd_pc), 32'h105);
    checkOutput("t4_pop_105_idx", 32'(o_upd_index), 32'h06);
    step();
    idle();
    checkOutput("t4_pop_106", 32'(o_upd_pc), 32'h106);
    checkOutput("t4_no_flush", 32'(o_flush), 32'd0);
    checkOutput("t4_ready_empty", 32'(o_fetch_ready), 32'd1);

    // ---- stall blocks push, pop and update ----
    $display("[TB] stall");
    applyStimulus(1'b1, 22'h200, 1'b0, 8'h07, 1'b0, 1'b0, 22'h0, 1'b0);
    step();
    applyStimulus(1'b1, 22'h210, 1'b0, 8'h08, 1'b1, 1'b0, 22'h0, 1'b1);
    step();
    checkOutput("st_no_upd", 32'(o_upd_valid), 32'd0);
    applyStimulus(1'b0, 22'h0, 1'b0, 8'h0, 1'b1, 1'b0, 22'h0, 1'b0);
    step();
    checkOutput("st_upd_valid", 32'(o_upd_valid), 32'd1);
    checkOutput("st_upd_pc", 32'(o_upd_pc), 32'h200);
    checkOutput("st_no_redirect", 32'(o_redirect_valid), 32'd0);
    step();
    idle();
    checkOutput("st_push_blocked", 32'(o_upd_valid), 32'd0);

    // ---- flush countdown continues under stall ----
    $display("[TB] flush under stall");
    applyStimulus(1'b1, 22'h300, 1'b1, 8'h09, 1'b0, 1'b0, 22'h0, 1'b0);
    step();
    applyStimulus(1'b0, 22'h0, 1'b0, 8'h0, 1'b1, 1'b0, 22'h0, 1'b0);
    step();
    applyStimulus(1'b0, 22'h0, 1'b0, 8'h0, 1'b0, 1'b0, 22'h0, 1'b1);
    checkOutput("fs_count", 32'(o_mispredict_count), 32'd3);
    checkOutput("fs_redirect_pc", 32'(o_redirect_pc), 32'h301);
    step();
    checkOutput("fs_flush_c2", 32'(o_flush), 32'd1);
    step();
    idle();
    checkOutput("fs_flush_end", 32'(o_flush), 32'd0);

    // ---- 6: saturation, counter preloaded just below the limit ----
    $display("[TB] counter saturation");
    force dut.r_mispredict_count = 16'hFFFE;
    #1;
    release dut.r_mispredict_count;
    applyStimulus(1'b1, 22'h400, 1'b0, 8'h0A, 1'b0, 1'b0, 22'h0, 1'b0);
    step();
    applyStimulus(1'b0, 22'h0, 1'b0, 8'h0, 1'b1, 1'b1, 22'h123, 1'b0);
    step();
    idle();
    checkOutput("sat_reach", 32'(o_mispredict_count), 32'hFFFF);
    checkOutput("sat_redirect_pc", 32'(o_redirect_pc), 32'h123);
    step();
    step();
    applyStimulus(1'b1, 22'h500, 1'b1, 8'h0B, 1'b0, 1'b0, 22'h0, 1'b0);
    step();
    applyStimulus(1'b0, 22'h0, 1'b0, 8'h0, 1'b1, 1'b0, 22'h0, 1'b0);
    step();
    idle();
    checkOutput("sat_hold", 32'(o_mispredict_count), 32'hFFFF);
    checkOutput("sat_redirect_pc2", 32'(o_redirect_pc), 32'h501);
    step();
    step();

    // ---- reset asserted mid-FLUSH ----
    $display("[TB] reset during flush");
    applyStimulus(1'b1, 22'h600, 1'b0, 8'h0C, 1'b0, 1'b0, 22'h0, 1'b0);
    step();
    applyStimulus(1'b0, 22'h0, 1'b0, 8'h0, 1'b1, 1'b1, 22'h7, 1'b0);
    step();
    idle();
    checkOutput("rf_in_flush", 32'(o_flush), 32'd1);
    i_Reset = 1'b1;
    #1;
    checkOutput("rf_flush_cleared", 32'(o_flush), 32'd0);
    checkOutput("rf_count_cleared", 32'(o_mispredict_count), 32'd0);
    checkOutput("rf_redirect_cleared", 32'(o_redirect_valid), 32'd0);
    checkOutput("rf_underflow_cleared", 32'(o_underflow), 32'd0);
    step();
    i_Reset = 1'b0;
    step();
    checkOutput("rf_ready", 32'(o_fetch_ready), 32'd1);
    checkOutput("rf_flush_stays_low", 32'(o_flush), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
